// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core control FSM (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        C_DOLOAD;
    logic        C_DOSTORE;
    logic [31:0] ADDR;
    logic [31:0] WDATA;
    logic [2:0]  FUNCT3;
    logic [31:0] RDATA;
    logic        C_MEM_DONE;
    logic        MEM_ERR;

    modport master (
        output C_DOLOAD, C_DOSTORE, ADDR, WDATA, FUNCT3,
        input  RDATA, C_MEM_DONE, MEM_ERR
    );

    modport slave (
        input  C_DOLOAD, C_DOSTORE, ADDR, WDATA, FUNCT3,
        output RDATA, C_MEM_DONE, MEM_ERR
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering level-held load/store requests with programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them down.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input logic              CLK,
    input logic              RST,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        store_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]      off_words;
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             misaligned;
    logic             access_err;
    logic [1:0]       lane;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rd_shifted;
    logic [31:0]      load_val;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        off_words   = addr_q[31:2] - BASE_ADDR[31:2];
        word_idx    = off_words[IDX_W-1:0];
        in_range    = (addr_q >= BASE_ADDR) && ({2'b00, off_words} < 32'(DEPTH_WORDS));
        misaligned  = 1'b0;
        lane        = addr_q[1:0];
        byte_en     = 4'b1111;
        wdata_lanes = wdata_q;
        load_val    = '0;

        // FUNCT3[1:0]: 00 byte, 01 half, 1x word (reserved codes behave as word)
        case (funct3_q[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                misaligned  = addr_q[0];
                lane        = {addr_q[1], 1'b0};
                byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                misaligned = (addr_q[1:0] != 2'b00);
                lane       = 2'b00;
            end
        endcase

`ifdef DMEM_MISALIGN_TRAP_EN
        access_err = !in_range || misaligned;
`else
        access_err = !in_range;
`endif

        rd_shifted = mem[word_idx] >> {lane, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_val = {24'h0, rd_shifted[7:0]};
            3'b101:  load_val = {16'h0, rd_shifted[15:0]};
            default: load_val = rd_shifted;
        endcase
    end

    // NOTE: RAM contents have no reset; only the control state does, which also keeps the array mappable to block RAM.
    always_ff @(posedge CLK) begin
        if (state == S_ACCESS && store_q && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            funct3_q       <= '0;
            store_q        <= 1'b0;
            bus.RDATA      <= '0;
            bus.C_MEM_DONE <= 1'b0;
            bus.MEM_ERR    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.C_DOLOAD || bus.C_DOSTORE) begin
                        addr_q   <= bus.ADDR;
                        wdata_q  <= bus.WDATA;
                        funct3_q <= bus.FUNCT3;
                        store_q  <= bus.C_DOSTORE;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (!store_q) bus.RDATA <= access_err ? 32'h0 : load_val;
                    bus.C_MEM_DONE <= 1'b1;
                    bus.MEM_ERR    <= access_err;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    bus.C_MEM_DONE <= 1'b0;
                    bus.MEM_ERR    <= 1'b0;
                    state          <= S_RELEASE;
                end
                S_RELEASE: begin
                    // a still-held request must not start a second access
                    if (!bus.C_DOLOAD && !bus.C_DOSTORE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2, BASE_ADDR=0x0001_0000, 1024 words).
module tb_dmem_responder;

    localparam int LAT = 4; // WAIT_CYCLES + 2

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    dmem_responder_if dif ();

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'h0001_0000)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (dif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until C_MEM_DONE is seen; scrambles the bus after the capture edge.
    task automatic wait_done(input string tag, input bit scramble);
        int  lat;
        bit  found;
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge CLK);
            #1;
            lat++;
            if (i == 0 && scramble) begin
                dif.ADDR   = 32'h0;
                dif.WDATA  = 32'h0BAD_0BAD;
                dif.FUNCT3 = 3'b111;
            end
            if (dif.C_MEM_DONE === 1'b1) found = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic xfer(input string tag, input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er);
        @(negedge CLK);
        dif.ADDR      = a;
        dif.WDATA     = wd;
        dif.FUNCT3    = f3;
        dif.C_DOSTORE = st;
        dif.C_DOLOAD  = !st;
        wait_done(tag, 1'b1);
        rd = dif.RDATA;
        er = dif.MEM_ERR;
        @(posedge CLK);
        #1;
        check({tag, "_pulse_width"}, {31'h0, dif.C_MEM_DONE}, 32'h0);
        check({tag, "_err_clear"}, {31'h0, dif.MEM_ERR}, 32'h0);
        @(negedge CLK);
        dif.C_DOLOAD  = 1'b0;
        dif.C_DOSTORE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          pulses;

        RST           = 1'b1;
        dif.C_DOLOAD  = 1'b0;
        dif.C_DOSTORE = 1'b0;
        dif.ADDR      = '0;
        dif.WDATA     = '0;
        dif.FUNCT3    = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rdata", dif.RDATA, 32'h0);
        check("rst_done", {31'h0, dif.C_MEM_DONE}, 32'h0);
        check("rst_err", {31'h0, dif.MEM_ERR}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // word store then load
        xfer("sw_beef", 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 3'b010, rd, er);
        check("sw_beef_rdata_kept", rd, 32'h0);
        check("sw_beef_err", {31'h0, er}, 32'h0);
        xfer("lw_beef", 1'b0, 32'h0001_0010, 32'h0, 3'b010, rd, er);
        check("lw_beef_rdata", rd, 32'hDEAD_BEEF);
        check("lw_beef_err", {31'h0, er}, 32'h0);

        // sub-word loads with extension
        xfer("lb", 1'b0, 32'h0001_0011, 32'h0, 3'b000, rd, er);
        check("lb_rdata", rd, 32'hFFFF_FFBE);
        xfer("lbu", 1'b0, 32'h0001_0011, 32'h0, 3'b100, rd, er);
        check("lbu_rdata", rd, 32'h0000_00BE);
        xfer("lh", 1'b0, 32'h0001_0012, 32'h0, 3'b001, rd, er);
        check("lh_rdata", rd, 32'hFFFF_DEAD);
        xfer("lhu", 1'b0, 32'h0001_0012, 32'h0, 3'b101, rd, er);
        check("lhu_rdata", rd, 32'h0000_DEAD);

        // sub-word stores
        xfer("sb", 1'b1, 32'h0001_0012, 32'hFFFF_FF55, 3'b000, rd, er);
        check("sb_rdata_kept", rd, 32'h0000_DEAD);
        xfer("lw_sb", 1'b0, 32'h0001_0010, 32'h0, 3'b010, rd, er);
        check("lw_sb_rdata", rd, 32'hDE55_BEEF);
        xfer("sh", 1'b1, 32'h0001_0012, 32'h1234_CAFE, 3'b001, rd, er);
        xfer("lbu_sh", 1'b0, 32'h0001_0013, 32'h0, 3'b100, rd, er);
        check("lbu_sh_rdata", rd, 32'h0000_00CA);
        xfer("lw_rsvd", 1'b0, 32'h0001_0010, 32'h0, 3'b110, rd, er);
        check("lw_rsvd_rdata", rd, 32'hCAFE_BEEF);

        // held request must not re-trigger; drop for one cycle then re-raise
        @(negedge CLK);
        dif.ADDR     = 32'h0001_0010;
        dif.FUNCT3   = 3'b010;
        dif.C_DOLOAD = 1'b1;
        wait_done("hold_first", 1'b0);
        pulses = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (dif.C_MEM_DONE === 1'b1) pulses++;
        end
        check("hold_no_repulse", 32'(pulses), 32'h0);
        @(negedge CLK);
        dif.C_DOLOAD = 1'b0;
        @(negedge CLK);
        dif.C_DOLOAD = 1'b1;
        wait_done("hold_second", 1'b0);
        @(negedge CLK);
        dif.C_DOLOAD = 1'b0;
        @(negedge CLK);

        // range boundaries
        xfer("sw_last", 1'b1, 32'h0001_0FFC, 32'h0A0B_0C0D, 3'b010, rd, er);
        check("sw_last_err", {31'h0, er}, 32'h0);
        xfer("lw_last", 1'b0, 32'h0001_0FFC, 32'h0, 3'b010, rd, er);
        check("lw_last_rdata", rd, 32'h0A0B_0C0D);
        xfer("lw_above", 1'b0, 32'h0001_1000, 32'h0, 3'b010, rd, er);
        check("lw_above_rdata", rd, 32'h0);
        check("lw_above_err", {31'h0, er}, 32'h1);
        xfer("sw_first", 1'b1, 32'h0001_0000, 32'h5A5A_5A5A, 3'b010, rd, er);
        xfer("sw_above", 1'b1, 32'h0001_1000, 32'hFFFF_FFFF, 3'b010, rd, er);
        check("sw_above_err", {31'h0, er}, 32'h1);
        xfer("lw_first", 1'b0, 32'h0001_0000, 32'h0, 3'b010, rd, er);
        check("lw_first_rdata", rd, 32'h5A5A_5A5A);
        xfer("lw_zero", 1'b0, 32'h0000_0000, 32'h0, 3'b010, rd, er);
        check("lw_zero_rdata", rd, 32'h0);
        check("lw_zero_err", {31'h0, er}, 32'h1);

        // reset during WAIT of a store aborts it
        xfer("sw_pre", 1'b1, 32'h0001_0020, 32'h1111_1111, 3'b010, rd, er);
        xfer("lw_pre", 1'b0, 32'h0001_0020, 32'h0, 3'b010, rd, er);
        check("lw_pre_rdata", rd, 32'h1111_1111);
        @(negedge CLK);
        dif.ADDR      = 32'h0001_0020;
        dif.WDATA     = 32'h2222_2222;
        dif.FUNCT3    = 3'b010;
        dif.C_DOSTORE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("abort_rdata_rst", dif.RDATA, 32'h0);
        check("abort_done_rst", {31'h0, dif.C_MEM_DONE}, 32'h0);
        @(negedge CLK);
        dif.C_DOSTORE = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (dif.C_MEM_DONE === 1'b1) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'h0);
        xfer("lw_post", 1'b0, 32'h0001_0020, 32'h0, 3'b010, rd, er);
        check("lw_post_rdata", rd, 32'h1111_1111);

        // misaligned accesses (word at 0x0001_0010 holds 0xCAFEBEEF)
        xfer("lh_mis", 1'b0, 32'h0001_0011, 32'h0, 3'b001, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lh_mis_rdata", rd, 32'h0);
        check("lh_mis_err", {31'h0, er}, 32'h1);
`else
        check("lh_mis_rdata", rd, 32'hFFFF_BEEF);
        check("lh_mis_err", {31'h0, er}, 32'h0);
`endif
        xfer("lw_mis", 1'b0, 32'h0001_0012, 32'h0, 3'b010, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_mis_rdata", rd, 32'h0);
        check("lw_mis_err", {31'h0, er}, 32'h1);
`else
        check("lw_mis_rdata", rd, 32'hCAFE_BEEF);
        check("lw_mis_err", {31'h0, er}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
